// File: rtl/hazard_unit.sv
// Pipeline hazard control: load-use stall, branch flush, data-memory wait stall with timeout.
// Outputs are combinational in the same cycle; the FSM and counters update on the clk edge.
module hazard_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ResultSrcE0,
   input  logic [4:0]  RD_E,
   input  logic [4:0]  Rs1_D,
   input  logic [4:0]  Rs2_D,
   input  logic        PCSrcE,
   input  logic        MemReqM,
   input  logic        MemReadyM,
   output logic        StallF,
   output logic        StallD,
   output logic        StallE,
   output logic        StallM,
   output logic        FlushD,
   output logic        FlushE,
   output logic        MemErr,
   output logic [15:0] StallCount,
   output logic [15:0] FlushCount
);

   typedef enum logic {
      RUN   = 1'b0,
      MWAIT = 1'b1
   } state_t;

   localparam logic [7:0] TO_VAL = 8'(TIMEOUT_CYCLES);

   state_t     state, state_nxt;
   logic [7:0] wait_cnt, wait_cnt_nxt;
   logic       mem_err_nxt;
   logic       to, mem_stall, lu, redirect;

   always_comb begin
      to        = (state == MWAIT) && (wait_cnt == TO_VAL);
      mem_stall = MemReqM & ~MemReadyM & ~to;
      lu        = ResultSrcE0 & (RD_E != 5'd0) & ((RD_E == Rs1_D) | (RD_E == Rs2_D));

      StallF   = 1'b0;
      StallD   = 1'b0;
      StallE   = 1'b0;
      StallM   = 1'b0;
      FlushD   = 1'b0;
      FlushE   = 1'b0;
      redirect = 1'b0;

      // Reset masks every control output, whatever the pipeline presents.
      if (rst) begin
         if (mem_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
         end else if (PCSrcE) begin
            FlushD   = 1'b1;
            FlushE   = 1'b1;
            redirect = 1'b1;
         end else if (lu) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      mem_err_nxt  = MemErr;
      case (state)
         RUN: begin
            if (mem_stall) begin
               state_nxt    = MWAIT;
               wait_cnt_nxt = 8'd1;
            end
         end
         MWAIT: begin
            if (mem_stall) begin
               wait_cnt_nxt = wait_cnt + 8'd1;
            end else begin
               // Timed out with the access still outstanding: abandon it and flag.
               if (to && MemReqM && !MemReadyM) mem_err_nxt = 1'b1;
               state_nxt    = RUN;
               wait_cnt_nxt = 8'd0;
            end
         end
         default: begin
            state_nxt    = RUN;
            wait_cnt_nxt = 8'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= RUN;
         wait_cnt   <= 8'd0;
         MemErr     <= 1'b0;
         StallCount <= 16'd0;
         FlushCount <= 16'd0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
         MemErr   <= mem_err_nxt;
         if (StallF && (StallCount != 16'hFFFF)) StallCount <= StallCount + 16'd1;
         if (redirect && (FlushCount != 16'hFFFF)) FlushCount <= FlushCount + 16'd1;
      end
   end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit with TIMEOUT_CYCLES=4.
module tb_hazard_unit;

   logic        clk;
   logic        rst;
   logic        ResultSrcE0;
   logic [4:0]  RD_E, Rs1_D, Rs2_D;
   logic        PCSrcE, MemReqM, MemReadyM;
   logic        StallF, StallD, StallE, StallM, FlushD, FlushE, MemErr;
   logic [15:0] StallCount, FlushCount;
   logic [5:0]  outs;

   int pass_cnt = 0;
   int total_cnt = 0;

   hazard_unit #(.TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst(rst),
      .ResultSrcE0(ResultSrcE0), .RD_E(RD_E), .Rs1_D(Rs1_D), .Rs2_D(Rs2_D),
      .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
      .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
      .FlushD(FlushD), .FlushE(FlushE), .MemErr(MemErr),
      .StallCount(StallCount), .FlushCount(FlushCount)
   );

   // {StallF, StallD, StallE, StallM, FlushD, FlushE}
   assign outs = {StallF, StallD, StallE, StallM, FlushD, FlushE};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      ResultSrcE0 = 1'b0; RD_E = 5'd0; Rs1_D = 5'd0; Rs2_D = 5'd0;
      PCSrcE = 1'b0; MemReqM = 1'b0; MemReadyM = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      idle_inputs();
      PCSrcE = 1'b1; MemReqM = 1'b1; ResultSrcE0 = 1'b1; RD_E = 5'd3; Rs1_D = 5'd3;
      #2;
      total_cnt++;
      if (outs !== 6'b000000) $display("FAIL reset_outs got %b want 000000", outs);
      else pass_cnt++;
      step(); step();
      total_cnt++;
      if (MemErr !== 1'b0 || StallCount !== 16'd0 || FlushCount !== 16'd0)
         $display("FAIL reset_state got err=%b sc=%0d fc=%0d want 0/0/0", MemErr, StallCount, FlushCount);
      else pass_cnt++;
      idle_inputs();
      rst = 1'b1;
      step();
   endtask

   task automatic test_idle_and_single_access();
      idle_inputs();
      #1;
      total_cnt++;
      if (outs !== 6'b000000) $display("FAIL idle_outs got %b want 000000", outs);
      else pass_cnt++;
      MemReqM = 1'b1; MemReadyM = 1'b1;
      for (int i = 0; i < 2; i++) begin
         #1;
         total_cnt++;
         if (outs !== 6'b000000) $display("FAIL single_access got %b want 000000", outs);
         else pass_cnt++;
         step();
      end
      idle_inputs();
      #1;
      total_cnt++;
      if (StallCount !== 16'd0) $display("FAIL single_access_cnt got %0d want 0", StallCount);
      else pass_cnt++;
   endtask

   task automatic test_load_use();
      idle_inputs();
      ResultSrcE0 = 1'b1; RD_E = 5'd5; Rs1_D = 5'd3; Rs2_D = 5'd5;
      #1;
      total_cnt++;
      if (outs !== 6'b110001) $display("FAIL load_use_rs2 got %b want 110001", outs);
      else pass_cnt++;
      step();
      idle_inputs();
      #1;
      total_cnt++;
      if (outs !== 6'b000000 || StallCount !== 16'd1)
         $display("FAIL load_use_after got outs=%b sc=%0d want 000000/1", outs, StallCount);
      else pass_cnt++;
      ResultSrcE0 = 1'b1; RD_E = 5'd7; Rs1_D = 5'd7; Rs2_D = 5'd2;
      #1;
      total_cnt++;
      if (outs !== 6'b110001) $display("FAIL load_use_rs1 got %b want 110001", outs);
      else pass_cnt++;
      step();
      ResultSrcE0 = 1'b0;
      #1;
      total_cnt++;
      if (outs !== 6'b000000 || StallCount !== 16'd2)
         $display("FAIL not_load got outs=%b sc=%0d want 000000/2", outs, StallCount);
      else pass_cnt++;
      step();
   endtask

   task automatic test_x0();
      idle_inputs();
      ResultSrcE0 = 1'b1; RD_E = 5'd0; Rs1_D = 5'd0; Rs2_D = 5'd0;
      #1;
      total_cnt++;
      if (outs !== 6'b000000) $display("FAIL x0_outs got %b want 000000", outs);
      else pass_cnt++;
      step();
      total_cnt++;
      if (StallCount !== 16'd2 || FlushCount !== 16'd0)
         $display("FAIL x0_cnt got sc=%0d fc=%0d want 2/0", StallCount, FlushCount);
      else pass_cnt++;
   endtask

   task automatic test_simultaneous();
      idle_inputs();
      PCSrcE = 1'b1; ResultSrcE0 = 1'b1; RD_E = 5'd9; Rs1_D = 5'd9;
      #1;
      total_cnt++;
      if (outs !== 6'b000011) $display("FAIL simul_outs got %b want 000011", outs);
      else pass_cnt++;
      step();
      idle_inputs();
      #1;
      total_cnt++;
      if (FlushCount !== 16'd1 || StallCount !== 16'd2)
         $display("FAIL simul_cnt got fc=%0d sc=%0d want 1/2", FlushCount, StallCount);
      else pass_cnt++;
   endtask

   task automatic test_mem_wait();
      idle_inputs();
      MemReqM = 1'b1; MemReadyM = 1'b0; PCSrcE = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         total_cnt++;
         if (outs !== 6'b111100) $display("FAIL mem_wait_stall cycle %0d got %b want 111100", i, outs);
         else pass_cnt++;
         step();
      end
      MemReadyM = 1'b1;
      #1;
      total_cnt++;
      if (outs !== 6'b000011) $display("FAIL mem_wait_release got %b want 000011", outs);
      else pass_cnt++;
      step();
      idle_inputs();
      #1;
      total_cnt++;
      if (StallCount !== 16'd5 || FlushCount !== 16'd2 || MemErr !== 1'b0)
         $display("FAIL mem_wait_after got sc=%0d fc=%0d err=%b want 5/2/0", StallCount, FlushCount, MemErr);
      else pass_cnt++;
   endtask

   task automatic test_timeout();
      idle_inputs();
      MemReqM = 1'b1; MemReadyM = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         total_cnt++;
         if (outs !== 6'b111100) $display("FAIL timeout_stall cycle %0d got %b want 111100", i, outs);
         else pass_cnt++;
         step();
      end
      #1;
      total_cnt++;
      if (outs !== 6'b000000 || MemErr !== 1'b0)
         $display("FAIL timeout_release got outs=%b err=%b want 000000/0", outs, MemErr);
      else pass_cnt++;
      step();
      idle_inputs();
      #1;
      total_cnt++;
      if (MemErr !== 1'b1 || StallCount !== 16'd9)
         $display("FAIL timeout_err got err=%b sc=%0d want 1/9", MemErr, StallCount);
      else pass_cnt++;
      step(); step(); step();
      total_cnt++;
      if (MemErr !== 1'b1) $display("FAIL timeout_sticky got %b want 1", MemErr);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      idle_inputs();
      MemReqM = 1'b1; MemReadyM = 1'b0; PCSrcE = 1'b1;
      #1;
      total_cnt++;
      if (outs !== 6'b111100) $display("FAIL reset_mid_pre got %b want 111100", outs);
      else pass_cnt++;
      step(); step();
      rst = 1'b0;
      #1;
      total_cnt++;
      if (outs !== 6'b000000 || MemErr !== 1'b0 || StallCount !== 16'd0 || FlushCount !== 16'd0)
         $display("FAIL reset_mid_abort got outs=%b err=%b sc=%0d fc=%0d want 000000/0/0/0",
                  outs, MemErr, StallCount, FlushCount);
      else pass_cnt++;
      step();
      PCSrcE = 1'b0;
      rst = 1'b1;
      // A fresh RUN state gives a full 4-cycle wait before the timeout release.
      for (int i = 0; i < 4; i++) begin
         #1;
         total_cnt++;
         if (outs !== 6'b111100) $display("FAIL reset_mid_resume cycle %0d got %b want 111100", i, outs);
         else pass_cnt++;
         step();
      end
      #1;
      total_cnt++;
      if (outs !== 6'b000000 || StallCount !== 16'd4 || MemErr !== 1'b0)
         $display("FAIL reset_mid_end got outs=%b sc=%0d err=%b want 000000/4/0", outs, StallCount, MemErr);
      else pass_cnt++;
      step();
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_idle_and_single_access();
      test_load_use();
      test_x0();
      test_simultaneous();
      test_mem_wait();
      test_timeout();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
